cache_front_end_arb: RTL and testbench

- Multi-requester front-end for the cache: N_PORTS native-interface requesters share one cache data path and one cache-control path.
- Round-robin arbiter picks one pending request. The request is registered and presented to the back-end. The completion (ready/rdata) is routed back to the granted port only.
- Successor of the single-port front-end. Adds port count, arbitration and committed-transaction semantics.

---
 rtl/cache_front_end_arb.sv | 175 +++++++++++++++++
 tb/tb_cache_front_end_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_front_end_arb.sv
// Multi-port cache front-end with round-robin arbitration.
//
// N_PORTS requesters share one cache data path and one cache-control path.
// In IDLE the arbiter picks the first requesting port, starting just after
// the previously served port. It registers that port's request and then
// presents it to the back-end in BUSY. The back-end completion (ready/rdata)
// is routed combinationally to the granted port only. Once granted, a
// request is committed: later changes on the requester side are ignored
// until it completes.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   p_valid/p_addr/p_wdata/p_wstrb   per-port requests (port i at slice i)
//   p_ready/p_rdata  per-port completion pulse and read data
//   data_*           cache memory request / completion
//   ctrl_*           cache-control request / completion
//   grant_sel        index of the port currently (or last) served
module cache_front_end_arb #(
    parameter int FE_ADDR_W   = 32,
    parameter int FE_DATA_W   = 32,
    parameter int N_PORTS     = 2,
    parameter int CTRL_CACHE  = 0,
    parameter int CTRL_ADDR_W = 5,
    localparam int FE_NBYTES  = FE_DATA_W / 8,
    localparam int FE_BYTE_W  = $clog2(FE_NBYTES),
    localparam int SEL_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    localparam int PA_W       = CTRL_CACHE + FE_ADDR_W,
    localparam int WA_W       = FE_ADDR_W - FE_BYTE_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_PORTS-1:0]             p_valid,
    input  logic [N_PORTS*PA_W-1:0]        p_addr,
    input  logic [N_PORTS*FE_DATA_W-1:0]   p_wdata,
    input  logic [N_PORTS*FE_NBYTES-1:0]   p_wstrb,
    output logic [N_PORTS-1:0]             p_ready,
    output logic [N_PORTS*FE_DATA_W-1:0]   p_rdata,
    output logic                           data_valid,
    output logic [WA_W-1:0]                data_addr,
    output logic [FE_DATA_W-1:0]           data_wdata,
    output logic [FE_NBYTES-1:0]           data_wstrb,
    input  logic [FE_DATA_W-1:0]           data_rdata,
    input  logic                           data_ready,
    output logic                           ctrl_valid,
    output logic [CTRL_ADDR_W-1:0]         ctrl_addr,
    input  logic [FE_DATA_W-1:0]           ctrl_rdata,
    input  logic                           ctrl_ready,
    output logic [SEL_W-1:0]               grant_sel
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       grant_q, grant_d;
    logic [SEL_W-1:0]       last_grant_q, last_grant_d;
    logic [WA_W-1:0]        waddr_q, waddr_d;
    logic [FE_DATA_W-1:0]   wdata_q, wdata_d;
    logic [FE_NBYTES-1:0]   wstrb_q, wstrb_d;
    logic                   is_ctrl_q, is_ctrl_d;

    // Per-port views of the flattened request buses.
    logic [PA_W-1:0]        addr_arr  [N_PORTS];
    logic [FE_DATA_W-1:0]   wdata_arr [N_PORTS];
    logic [FE_NBYTES-1:0]   wstrb_arr [N_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = p_addr[gi*PA_W +: PA_W];
            assign wdata_arr[gi] = p_wdata[gi*FE_DATA_W +: FE_DATA_W];
            assign wstrb_arr[gi] = p_wstrb[gi*FE_NBYTES +: FE_NBYTES];
        end
    endgenerate

    // Round-robin search: candidates last_grant+1, +2, ... wrapping modulo
    // N_PORTS, so the last served port is checked last.
    logic                   arb_found;
    logic [SEL_W-1:0]       arb_idx;
    logic [SEL_W-1:0]       cand_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand_idx = SEL_W'((int'(last_grant_q) + k) % N_PORTS);
            if (!arb_found && p_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    logic [PA_W-1:0] sel_addr;
    logic            unused_addr_bits;
    assign sel_addr         = addr_arr[arb_idx];
    // Byte-offset bits never reach the back-end.
    assign unused_addr_bits = ^sel_addr[FE_BYTE_W-1:0];

    logic busy;
    logic done;
    logic [FE_DATA_W-1:0] resp_data;

    assign busy      = (state_q == S_BUSY);
    // Only the back-end the request went to may complete it.
    assign done      = busy && (is_ctrl_q ? ctrl_ready : data_ready);
    assign resp_data = is_ctrl_q ? ctrl_rdata : data_rdata;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        is_ctrl_d    = is_ctrl_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d   = S_BUSY;
                    grant_d   = arb_idx;
                    waddr_d   = sel_addr[FE_ADDR_W-1:FE_BYTE_W];
                    wdata_d   = wdata_arr[arb_idx];
                    wstrb_d   = wstrb_arr[arb_idx];
                    is_ctrl_d = (CTRL_CACHE != 0) && sel_addr[PA_W-1];
                end
            end
            S_BUSY: begin
                if (done) begin
                    state_d      = S_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= SEL_W'(N_PORTS - 1);
            waddr_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            is_ctrl_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            is_ctrl_q    <= is_ctrl_d;
        end
    end

    // Back-end request outputs come straight from state flops; payload is
    // forced to zero whenever the corresponding path is not requesting.
    assign data_valid = busy && !is_ctrl_q;
    assign data_addr  = data_valid ? waddr_q : '0;
    assign data_wdata = data_valid ? wdata_q : '0;
    assign data_wstrb = data_valid ? wstrb_q : '0;
    assign ctrl_valid = busy && is_ctrl_q;
    assign ctrl_addr  = ctrl_valid ? waddr_q[CTRL_ADDR_W-1:0] : '0;
    assign grant_sel  = grant_q;

    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_resp
            assign p_ready[gi] = done && (grant_q == SEL_W'(gi));
            assign p_rdata[gi*FE_DATA_W +: FE_DATA_W] = p_ready[gi] ? resp_data : '0;
        end
    endgenerate

endmodule

// File: tb/tb_cache_front_end_arb.sv
module tb_cache_front_end_arb;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NB  = 4;
    localparam int PA  = 33;
    localparam int SW  = 2;
    localparam int CAW = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    p_valid;
    logic [PA-1:0]   a_addr  [N];
    logic [DW-1:0]   a_wdata [N];
    logic [NB-1:0]   a_wstrb [N];
    logic [N*PA-1:0] p_addr;
    logic [N*DW-1:0] p_wdata;
    logic [N*NB-1:0] p_wstrb;
    logic [N-1:0]    p_ready;
    logic [N*DW-1:0] p_rdata;
    logic            data_valid;
    logic [AW-3:0]   data_addr;
    logic [DW-1:0]   data_wdata;
    logic [NB-1:0]   data_wstrb;
    logic [DW-1:0]   data_rdata;
    logic            data_ready;
    logic            ctrl_valid;
    logic [CAW-1:0]  ctrl_addr;
    logic [DW-1:0]   ctrl_rdata;
    logic            ctrl_ready;
    logic [SW-1:0]   grant_sel;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            p_addr[i*PA +: PA]  = a_addr[i];
            p_wdata[i*DW +: DW] = a_wdata[i];
            p_wstrb[i*NB +: NB] = a_wstrb[i];
        end
    end

    cache_front_end_arb #(
        .FE_ADDR_W(AW), .FE_DATA_W(DW), .N_PORTS(N),
        .CTRL_CACHE(1), .CTRL_ADDR_W(CAW)
    ) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_addr(p_addr), .p_wdata(p_wdata), .p_wstrb(p_wstrb),
        .p_ready(p_ready), .p_rdata(p_rdata),
        .data_valid(data_valid), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_wstrb(data_wstrb), .data_rdata(data_rdata), .data_ready(data_ready),
        .ctrl_valid(ctrl_valid), .ctrl_addr(ctrl_addr), .ctrl_rdata(ctrl_rdata),
        .ctrl_ready(ctrl_ready), .grant_sel(grant_sel)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: at most one outstanding committed request,
    // served in rotating priority order starting after the last served port.
    logic          m_busy = 1'b0;
    int            m_port = 0;
    int            m_last = N - 1;
    logic [PA-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [NB-1:0] m_wstrb = '0;
    logic          m_ctrl = 1'b0;
    logic          m_found;
    int            m_cand;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_last = N - 1;
        end else if (!m_busy) begin
            m_found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                m_cand = (m_last + k) % N;
                if (!m_found && p_valid[m_cand]) begin
                    m_found = 1'b1;
                    m_port  = m_cand;
                    m_addr  = a_addr[m_cand];
                    m_wdata = a_wdata[m_cand];
                    m_wstrb = a_wstrb[m_cand];
                    m_ctrl  = a_addr[m_cand][PA-1];
                    m_busy  = 1'b1;
                end
            end
        end else if (m_ctrl ? ctrl_ready : data_ready) begin
            m_busy = 1'b0;
            m_last = m_port;
        end
    end

    int   done_cnt [N];
    logic e_done;
    logic e_rdy;
    logic e_dv;
    logic e_cv;

    initial for (int i = 0; i < N; i++) done_cnt[i] = 0;

    always @(negedge clk) begin
        e_dv   = m_busy && !m_ctrl;
        e_cv   = m_busy && m_ctrl;
        e_done = m_busy && (m_ctrl ? ctrl_ready : data_ready);
        check("data_valid", data_valid, e_dv);
        check("data_addr",  data_addr,  e_dv ? m_addr[AW-1:2] : '0);
        check("data_wdata", data_wdata, e_dv ? m_wdata : '0);
        check("data_wstrb", data_wstrb, e_dv ? m_wstrb : '0);
        check("ctrl_valid", ctrl_valid, e_cv);
        check("ctrl_addr",  ctrl_addr,  e_cv ? m_addr[CAW+1:2] : '0);
        for (int i = 0; i < N; i++) begin
            e_rdy = e_done && (i == m_port);
            check($sformatf("p_ready[%0d]", i), p_ready[i], e_rdy);
            check($sformatf("p_rdata[%0d]", i), p_rdata[i*DW +: DW],
                  e_rdy ? (m_ctrl ? ctrl_rdata : data_rdata) : '0);
        end
        if (m_busy) check("grant_sel", grant_sel, m_port);
        if (e_done) begin
            done_cnt[m_port]++;
            $display("txn port %0d %s addr %h wstrb %h rdata %h", m_port,
                     m_ctrl ? "ctrl" : "data", m_addr, m_wstrb,
                     m_ctrl ? ctrl_rdata : data_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        p_valid = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0; a_wstrb[i] = '0;
        end
        data_ready = 1'b0; ctrl_ready = 1'b0;
        data_rdata = '0;   ctrl_rdata = '0;
    endtask

    int exp_g [4] = '{0, 1, 0, 1};
    int done_ack [N];
    int base_cnt;

    initial begin
        clear_all();
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst data_valid", data_valid, 1'b0);
        check("rst ctrl_valid", ctrl_valid, 1'b0);
        check("rst p_ready", p_ready, '0);
        check("rst grant_sel", grant_sel, '0);
        check("rst data_addr", data_addr, '0);
        step();
        reset = 1'b0;

        // Single read from port 0.
        p_valid[0] = 1'b1; a_addr[0] = 33'h10;
        @(negedge clk);
        check("rd idle data_valid", data_valid, 1'b0);
        step();
        @(negedge clk);
        check("rd data_valid", data_valid, 1'b1);
        check("rd data_addr", data_addr, 30'h4);
        check("rd no early ready", p_ready, 3'b000);
        step();
        data_ready = 1'b1; data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("rd p_ready", p_ready, 3'b001);
        check("rd p_rdata0", p_rdata[0 +: DW], 32'hDEADBEEF);
        check("rd p_rdata1", p_rdata[DW +: DW], 32'h0);
        step();
        data_ready = 1'b0; p_valid = '0;
        @(negedge clk);
        check("rd after data_valid", data_valid, 1'b0);

        // Contention after a fresh reset: strict alternation 0,1,0,1.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        data_ready = 1'b1; p_valid = 3'b011; a_addr[1] = 33'h4;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("cont grant", grant_sel, exp_g[k]);
            check("cont p_ready", p_ready, 3'(1 << exp_g[k]));
            step();
            @(negedge clk);
            check("cont idle gap", data_valid, 1'b0);
        end
        p_valid = '0; data_ready = 1'b0;

        // Write from port 1 held until data_ready.
        p_valid[1] = 1'b1; a_addr[1] = 33'h100; a_wdata[1] = 32'h12345678; a_wstrb[1] = 4'hF;
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wr wstrb", data_wstrb, 4'hF);
            check("wr wdata", data_wdata, 32'h12345678);
            check("wr addr", data_addr, 30'h40);
            check("wr wait ready", p_ready, 3'b000);
            step();
        end
        data_ready = 1'b1;
        @(negedge clk);
        check("wr p_ready", p_ready, 3'b010);
        step();
        data_ready = 1'b0; p_valid = '0; a_wstrb[1] = '0;

        // Control-space request; a stray data_ready must not complete it.
        p_valid[0] = 1'b1; a_addr[0] = {1'b1, 32'h0000000C};
        step();
        data_ready = 1'b1;
        @(negedge clk);
        check("ctl ctrl_valid", ctrl_valid, 1'b1);
        check("ctl ctrl_addr", ctrl_addr, 5'd3);
        check("ctl data_valid", data_valid, 1'b0);
        check("ctl ignore data_ready", p_ready, 3'b000);
        step();
        data_ready = 1'b0; ctrl_ready = 1'b1; ctrl_rdata = 32'h5;
        @(negedge clk);
        check("ctl p_ready", p_ready, 3'b001);
        check("ctl p_rdata0", p_rdata[0 +: DW], 32'h5);
        step();
        ctrl_ready = 1'b0; p_valid = '0;

        // Committed request: requester withdraws after the grant.
        p_valid[0] = 1'b1; a_addr[0] = 33'h20;
        step();
        step();
        p_valid[0] = 1'b0; a_addr[0] = 33'h44;
        base_cnt = done_cnt[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("cmt data_addr", data_addr, 30'h8);
            check("cmt wait", p_ready, 3'b000);
            step();
        end
        data_ready = 1'b1;
        @(negedge clk);
        check("cmt p_ready", p_ready, 3'b001);
        step();
        @(negedge clk);
        check("spurious idle ready", p_ready, 3'b000);
        check("cmt single pulse", done_cnt[0] - base_cnt, 1);
        step();
        data_ready = 1'b0;

        // Asynchronous reset in the middle of a BUSY transaction.
        p_valid[0] = 1'b1; a_addr[0] = 33'h30;
        step();
        @(negedge clk);
        check("rstb data_valid before", data_valid, 1'b1);
        #2 reset = 1'b1; data_ready = 1'b1;
        #1;
        check("rstb data_valid", data_valid, 1'b0);
        check("rstb p_ready", p_ready, 3'b000);
        step();
        reset = 1'b0; data_ready = 1'b0; p_valid = 3'b011; a_addr[1] = 33'h8;
        step();
        @(negedge clk);
        check("rstb first grant", grant_sel, 2'd0);
        check("rstb first dv", data_valid, 1'b1);
        step();
        data_ready = 1'b1;
        @(negedge clk);
        check("rstb p_ready", p_ready, 3'b001);
        step();
        p_valid[0] = 1'b0; data_ready = 1'b0;

        // Randomized traffic: requesters hold until their completion.
        for (int i = 0; i < N; i++) done_ack[i] = done_cnt[i];
        for (int c = 0; c < 1500; c++) begin
            step();
            data_ready = ($urandom % 3) == 0;
            ctrl_ready = ($urandom % 3) == 0;
            data_rdata = $urandom;
            ctrl_rdata = $urandom;
            for (int i = 0; i < N; i++) begin
                if (done_cnt[i] != done_ack[i]) begin
                    done_ack[i] = done_cnt[i];
                    p_valid[i]  = 1'b0;
                end else if (!p_valid[i] && ($urandom % 3) == 0) begin
                    p_valid[i]  = 1'b1;
                    a_addr[i]   = {1'(($urandom % 4) == 0), 32'($urandom)};
                    a_wdata[i]  = $urandom;
                    a_wstrb[i]  = ($urandom % 2) ? 4'h0 : 4'($urandom);
                end
            end
        end
        step();
        clear_all();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
